// File: rtl/drac_pkg.sv
// Shared types for the commit-trace path: per-lane commit payload and the
// tagged trace record delivered to the sink.
package drac_pkg;

  localparam int TRACE_SEQ_W   = 32;
  localparam int LANE_IDX_W    = 3;
  localparam int COMMIT_DATA_W = 32;
  localparam int DROP_CNT_W    = 32;

  typedef logic [COMMIT_DATA_W-1:0] commit_data_t;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic [LANE_IDX_W-1:0]  lane;
    commit_data_t           data;
  } trace_rec_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } trace_state_e;

endpackage

// File: rtl/commit_trace_if.sv
// Commit-side capture inputs and sink-side drain/status signals of the trace buffer.
interface commit_trace_if #(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 16
);
  import drac_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                          enable_i;
  logic                          clear_i;
  logic [NUM_LANES-1:0]          commit_valid_i;
  commit_data_t [NUM_LANES-1:0]  commit_data_i;
  logic                          trace_valid_o;
  trace_rec_t                    trace_data_o;
  logic                          trace_ready_i;
  logic                          overflow_o;
  logic [DROP_CNT_W-1:0]         drop_cnt_o;
  logic                          frozen_o;
  logic [CNT_W-1:0]              count_o;

  modport master (
    output enable_i, clear_i, commit_valid_i, commit_data_i, trace_ready_i,
    input  trace_valid_o, trace_data_o, overflow_o, drop_cnt_o, frozen_o, count_o
  );

  modport slave (
    input  enable_i, clear_i, commit_valid_i, commit_data_i, trace_ready_i,
    output trace_valid_o, trace_data_o, overflow_o, drop_cnt_o, frozen_o, count_o
  );

endinterface

// File: rtl/commit_trace_compact.sv
// Prefix popcount over the commit-valid lanes: each valid lane's slot offset
// inside the group, plus the group size k.
module commit_trace_compact #(
  parameter int NUM_LANES = 2,
  parameter int OFF_W     = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0]            valid,
  output logic [NUM_LANES-1:0][OFF_W-1:0] offset,
  output logic [OFF_W-1:0]                k
);

  logic [OFF_W-1:0] running;

  // NOTE: combinational blocks use blocking '=' and assign every output
  // before any conditional use, so the running sum chains and no latch forms.
  always_comb begin
    running = '0;
    offset  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      offset[i] = running;
      running   = running + OFF_W'(valid[i]);
    end
    k = running;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace collector: packs valid commit lanes into a circular buffer with
// running sequence tags and drains them one record per cycle to a trace sink.
module commit_trace_buffer
  import drac_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int DEPTH       = 16,
  parameter bit STOP_ON_OVF = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  commit_trace_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OFF_W = $clog2(NUM_LANES + 1);

  trace_state_e          state_q, state_d;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d, space;
  logic [TRACE_SEQ_W-1:0] seq_q;
  logic [DROP_CNT_W-1:0] drop_q, drop_next;
  logic [DROP_CNT_W:0]   drop_sum;
  logic                  ovf_q;
  trace_rec_t            mem [2**PTR_W];

  logic [NUM_LANES-1:0][OFF_W-1:0] offset;
  logic [OFF_W-1:0]                grp_k;
  logic                            capture, fits, accept, drop, pop;

  commit_trace_compact #(
    .NUM_LANES (NUM_LANES),
    .OFF_W     (OFF_W)
  ) u_compact (
    .valid  (bus.commit_valid_i),
    .offset (offset),
    .k      (grp_k)
  );

  // Space is judged against the pre-pop count: a same-cycle pop never makes room.
  assign capture = bus.enable_i && (state_q == ST_RUN);
  assign space   = CNT_W'(DEPTH) - count_q;
  assign fits    = 32'(grp_k) <= 32'(space);
  assign accept  = capture && fits;
  assign drop    = capture && !fits;
  assign pop     = (count_q != '0) && bus.trace_ready_i;

  assign count_d   = count_q + (accept ? CNT_W'(grp_k) : CNT_W'(0)) - CNT_W'(pop);
  assign drop_sum  = {1'b0, drop_q} + (DROP_CNT_W + 1)'(grp_k);
  assign drop_next = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];

  // NOTE: all sequential state uses non-blocking '<=' so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) tail_q <= tail_q + PTR_W'(grp_k);
      if (pop)    head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
      // Dropped groups still consume sequence numbers so the sink sees a gap.
      if (capture) seq_q <= seq_q + TRACE_SEQ_W'(grp_k);
      if (drop) begin
        drop_q <= drop_next;
        ovf_q  <= 1'b1;
      end
    end
  end

  // NOTE: the record storage has no reset; occupancy is tracked by count_q,
  // so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (accept && !bus.clear_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.commit_valid_i[i]) begin
          mem[tail_q + PTR_W'(offset[i])] <= '{
            seq:  seq_q + TRACE_SEQ_W'(offset[i]),
            lane: LANE_IDX_W'(i),
            data: bus.commit_data_i[i]
          };
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (drop && STOP_ON_OVF) state_d = ST_FROZEN;
      ST_FROZEN: state_d = ST_FROZEN;
      default:   state_d = ST_RUN;
    endcase
    if (bus.clear_i) state_d = ST_RUN;
  end

  always_comb begin
    bus.frozen_o = (state_q == ST_FROZEN);
  end

  // Head is read straight from storage (first-word-fall-through).
  assign bus.trace_valid_o = (count_q != '0);
  assign bus.trace_data_o  = mem[head_q];
  assign bus.count_o       = count_q;
  assign bus.drop_cnt_o    = drop_q;
  assign bus.overflow_o    = ovf_q;

endmodule
